// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low row at a time, synchronizes and
// debounces the columns, and holds ready high while one accepted key stays pressed.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] tecla,
  output logic       ready
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;

  state_e        state_q;
  logic [3:0]    sync1_q, col_s_q;
  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    cand_q, row_q, tecla_q;
  logic          ready_q;

  logic          strobe, is_none, is_single;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    row_next;
  logic [1:0]    row_idx, col_idx;

  function automatic logic [1:0] low_pos(input logic [3:0] v);
    logic [1:0] p;
    p = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (!v[i]) p = 2'(i);
    return p;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      col_s_q <= '1;
    end else begin
      sync1_q <= col;
      col_s_q <= sync1_q;
    end
  end

  // Rows only change on a strobe, so wrapping here also restarts the period for a new row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    div_q <= '0;
    else if (strobe) div_q <= '0;
    else             div_q <= div_q + DW'(1);
  end

  always_comb begin
    strobe    = (div_q == DIV_LAST);
    is_none   = (col_s_q == 4'hF);
    is_single = $onehot(~col_s_q);
    cnt_inc   = cnt_q + CNT_ONE;
    row_next  = {row_q[2:0], row_q[3]};
    row_idx   = low_pos(row_q);
    // On an accept edge col_s equals the candidate, so it serves both accept paths.
    col_idx   = low_pos(col_s_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      cand_q  <= '1;
      row_q   <= 4'b1110;
      tecla_q <= '0;
      ready_q <= 1'b0;
    end else if (strobe) begin
      unique case (state_q)
        SCAN: begin
          if (is_single) begin
            cand_q <= col_s_q;
            if (DEBOUNCE_CNT == 1) begin
              state_q <= PRESSED;
              tecla_q <= {row_idx, col_idx};
              ready_q <= 1'b1;
            end else begin
              state_q <= DEBOUNCE;
              cnt_q   <= CNT_ONE;
            end
          end else begin
            row_q <= row_next;
          end
        end
        DEBOUNCE: begin
          if (col_s_q == cand_q) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_q <= PRESSED;
              tecla_q <= {row_idx, col_idx};
              ready_q <= 1'b1;
            end
          end else begin
            state_q <= SCAN;
            row_q   <= row_next;
          end
        end
        PRESSED: begin
          if (is_none) begin
            if (DEBOUNCE_CNT == 1) begin
              state_q <= SCAN;
              ready_q <= 1'b0;
              row_q   <= row_next;
            end else begin
              state_q <= RELEASE;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (is_none) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_q <= SCAN;
              ready_q <= 1'b0;
              row_q   <= row_next;
            end
          end else begin
            state_q <= PRESSED;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row   = row_q;
  assign tecla = tecla_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the columns from the rows,
// and a strobe-level reference model predicts row, ready and tecla every cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  col, row, tecla;
  logic        ready;
  logic [15:0] pressed = '0;   // bit r*4+c set = key at row r, column c held down

  int errors = 0;
  int checks = 0;

  int         m_ridx, m_run, edges, rises;
  bit         m_held, prev_ready;
  logic [3:0] m_cand, m_tecla;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .reset_n(reset_n), .col(col), .row(row), .tecla(tecla), .ready(ready)
  );

  // A pressed key shorts its row to its column; a low row pulls that column low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] sample_at(input int r);
    logic [3:0] s;
    s = 4'hF;
    for (int c = 0; c < 4; c++)
      if (pressed[r*4+c]) s[c] = 1'b0;
    return s;
  endfunction

  function automatic int zeros(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) n++;
    return n;
  endfunction

  function automatic int zero_pos(input logic [3:0] v);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) p = i;
    return p;
  endfunction

  task automatic model_reset();
    m_ridx = 0; m_run = 0; m_held = 0; m_tecla = '0; m_cand = '1;
    edges = 0; prev_ready = 0;
  endtask

  // m_run counts consecutive samples agreeing with the current hypothesis (press or release).
  task automatic model_strobe();
    logic [3:0] s;
    s = sample_at(m_ridx);
    if (!m_held) begin
      if (m_run == 0) begin
        if (zeros(s) == 1) begin m_cand = s; m_run = 1; end
        else m_ridx = (m_ridx + 1) % 4;
      end else if (s == m_cand) begin
        m_run++;
      end else begin
        m_run = 0; m_ridx = (m_ridx + 1) % 4;
      end
      if (m_run == DB) begin
        m_held = 1; m_run = 0;
        m_tecla = 4'(m_ridx * 4 + zero_pos(m_cand));
      end
    end else if (zeros(s) == 0) begin
      m_run++;
      if (m_run == DB) begin m_held = 0; m_run = 0; m_ridx = (m_ridx + 1) % 4; end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick();
    logic [3:0] erow;
    @(posedge clk);
    edges++;
    if (edges % SCAN_DIV == 0) model_strobe();
    @(negedge clk);
    erow = 4'hF;
    erow[m_ridx] = 1'b0;
    check("row", row, erow);
    check("ready", ready, m_held);
    check("tecla", tecla, m_tecla);
    if (ready && !prev_ready) rises++;
    prev_ready = ready;
  endtask

  task automatic run_periods(input int n);
    for (int i = 0; i < n * SCAN_DIV; i++) tick();
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_row", row, 4'b1110);
    check("rst_ready", ready, 0);
    check("rst_tecla", tecla, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input string tag, input int bound_periods);
    for (int i = 0; i < bound_periods * SCAN_DIV && !ready; i++) tick();
    check(tag, ready, 1);
  endtask

  initial begin
    int k;
    rises = 0;
    pulse_reset();

    // Reset mid-scan, then free rotation.
    for (int i = 0; i < 6; i++) tick();
    pulse_reset();
    run_periods(4);

    // One-strobe bounce on row 0, then a two-column press on every row.
    pressed = 16'h0001;
    run_periods(1);
    pressed = '0;
    run_periods(1);
    check("bounce_row", row, 4'b1101);
    check("bounce_ready", ready, 0);
    pressed = 16'h3333;
    run_periods(8);
    check("multi_ready", ready, 0);

    // Key 9 (row 2, column 1).
    pressed = 16'h0200;
    rises = 0;
    wait_ready("press9_ready", 40);
    run_periods(4);
    check("press9_rises", rises, 1);
    check("press9_tecla", tecla, 4'd9);
    check("press9_row", row, 4'b1011);

    // Second key on the same row while 9 is held.
    pressed = 16'h0300;
    run_periods(6);
    check("extra_ready", ready, 1);
    check("extra_tecla", tecla, 4'd9);
    check("extra_rises", rises, 1);

    // Release glitch, then full release.
    pressed = '0;
    run_periods(1);
    pressed = 16'h0200;
    run_periods(2);
    check("glitch_ready", ready, 1);
    pressed = '0;
    run_periods(2);
    check("rel2_ready", ready, 1);
    run_periods(1);
    check("rel_ready", ready, 0);
    check("rel_tecla", tecla, 4'd9);
    check("rel_row", row, 4'b0111);
    check("rel_rises", rises, 1);

    // Reset while pressed, key re-detected.
    pressed = 16'h0200;
    wait_ready("pre_rst_ready", 40);
    run_periods(1);
    pulse_reset();
    wait_ready("redetect_ready", 40);
    check("redetect_tecla", tecla, 4'd9);

    // Random key activity against the reference model.
    for (int seg = 0; seg < 300; seg++) begin
      k = int'($urandom_range(0, 99));
      if (k < 15)       ; // keep current keys
      else if (k < 45)  pressed = '0;
      else if (k < 85)  pressed = 16'(1) << $urandom_range(0, 15);
      else              pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) pulse_reset();
      run_periods(int'($urandom_range(1, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
